// File: rtl/instr_fetch.sv
// Instruction fetch stage: feeds 16-bit words from a writable program memory to the processor.
// Define IFETCH_PREFETCH_EN to add a one-word prefetch buffer for zero-bubble issue on done.
module instr_fetch #(
  parameter int          ADDR_W    = 6,
  parameter int          DEPTH     = 64,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic              done,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       iin,
  output logic              iin_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HALT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] pc_inc;
  logic [15:0]       cur_word;

  // Explicit wrap so a DEPTH smaller than 2**ADDR_W still cycles correctly.
  assign pc_inc   = (pc == LAST) ? '0 : pc + 1'b1;
  assign cur_word = mem[pc];

  // Program memory is never reset; it is only writable while idle.
  always_ff @(posedge clock) begin
    if (state == IDLE && prog_we && prog_addr <= LAST)
      mem[prog_addr] <= prog_data;
  end

`ifdef IFETCH_PREFETCH_EN
  logic [15:0] pf_buf;
  logic        pf_loaded;
  logic [15:0] next_word;

  // A done on the very first WAIT cycle arrives before the buffer fills.
  assign next_word = pf_loaded ? pf_buf : mem[pc_inc];
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      pc        <= '0;
      iin       <= 16'h0000;
      iin_valid <= 1'b0;
      halted    <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
      pf_buf    <= 16'h0000;
      pf_loaded <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run)
            state <= FETCH;
        end
        FETCH: begin
          iin <= cur_word;
          if (cur_word == HALT_WORD) begin
            iin_valid <= 1'b0;
            halted    <= 1'b1;
            state     <= HALT;
          end else begin
            iin_valid <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
`ifdef IFETCH_PREFETCH_EN
          if (!pf_loaded) begin
            pf_buf    <= mem[pc_inc];
            pf_loaded <= 1'b1;
          end
          if (done) begin
            pc        <= pc_inc;
            pf_loaded <= 1'b0;
            if (!run) begin
              iin_valid <= 1'b0;
              state     <= IDLE;
            end else if (next_word == HALT_WORD) begin
              iin_valid <= 1'b0;
              halted    <= 1'b1;
              state     <= HALT;
            end else begin
              iin       <= next_word;
              iin_valid <= 1'b1;
            end
          end
`else
          if (done) begin
            pc        <= pc_inc;
            iin_valid <= 1'b0;
            state     <= run ? FETCH : IDLE;
          end
`endif
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
